// File: rtl/mfcc_pkg.sv
// Shared definitions for the MFCC front end: the framing state type, the
// pre-emphasis coefficient and a saturating truncation helper.
package mfcc_pkg;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    START   = 2'd1,
    SERVE   = 2'd2,
    ADVANCE = 2'd3
  } state_e;

  // 0.97 in Q15
  localparam int ALPHA_Q15 = 31785;

  // Clamp a wide signed value into the signed range of 'width' bits.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] value,
                                                   input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) begin
      return max_v;
    end
    if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/pre_emphasis.sv
// Pre-emphasis filter y = sat(x - ((ALPHA_Q15 * prev) >>> 15)).
// Only instantiated by framing_buffer when PRE_EMPHASIS_EN is defined.
module pre_emphasis
  import mfcc_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_i,
  input  logic                           accept_i,
  output logic signed [SAMPLE_WIDTH-1:0] sample_o
);

  localparam int PW = 2 * SAMPLE_WIDTH;

  logic signed [SAMPLE_WIDTH-1:0] prev_q;
  logic signed [SAMPLE_WIDTH-1:0] prev_d;
  logic signed [PW-1:0]           product;
  logic signed [PW-1:0]           scaled;
  logic signed [63:0]             diff;

  // Filter datapath; prev only advances on samples the buffer actually stores.
  always_comb begin
    product  = $signed(PW'(ALPHA_Q15)) * PW'(prev_q);
    scaled   = product >>> 15;
    diff     = 64'(sample_i) - 64'(scaled);
    sample_o = SAMPLE_WIDTH'(sat_trunc(diff, SAMPLE_WIDTH));
    prev_d   = accept_i ? sample_i : prev_q;
  end

  // Previous-input history register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/framing_buffer.sv
// Circular sample buffer that slices an audio stream into overlapping frames
// (FRAME_SIZE long, HOP_SIZE apart) and serves each frame on a rd_en/valid
// handshake. Define PRE_EMPHASIS_EN to filter samples before storage.
module framing_buffer
  import mfcc_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FRAME_SIZE   = 306,
  parameter int HOP_SIZE     = 128,
  parameter int BUFFER_DEPTH = 512
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_i,
  input  logic                           sample_valid_i,
  output logic                           start_o,
  input  logic                           rd_en_i,
  output logic signed [SAMPLE_WIDTH-1:0] frame_sample_o,
  output logic                           valid_to_read_o,
  output logic                           frame_done_o,
  output logic                           overflow_o
);

  localparam int PW = $clog2(BUFFER_DEPTH);
  localparam int OW = $clog2(BUFFER_DEPTH + 1);
  localparam int IW = $clog2(FRAME_SIZE + 1);

  state_e            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     base_ptr_q, base_ptr_d;
  logic [OW-1:0]     occupancy_q, occupancy_d;
  logic [IW-1:0]     rd_idx_q, rd_idx_d;
  logic              start_q, start_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic              have_data_q, have_data_d;

  logic                           accept;
  logic                           rd_fire;
  logic [PW-1:0]                  rd_addr;
  logic signed [SAMPLE_WIDTH-1:0] wr_data;
  logic signed [SAMPLE_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic signed [SAMPLE_WIDTH-1:0] rd_data_q;

  assign accept  = sample_valid_i && (occupancy_q < OW'(BUFFER_DEPTH));
  assign rd_fire = (state_q == SERVE) && rd_en_i && (rd_idx_q < IW'(FRAME_SIZE));
  assign rd_addr = base_ptr_q + PW'(rd_idx_q);

`ifdef PRE_EMPHASIS_EN
  pre_emphasis #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH)
  ) u_pre_emphasis (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample_i (sample_i),
    .accept_i (accept),
    .sample_o (wr_data)
  );
`else
  assign wr_data = sample_i;
`endif

  // Next-state logic for the write path and the frame sequencing FSM.
  always_comb begin
    state_d     = state_q;
    base_ptr_d  = base_ptr_q;
    rd_idx_d    = rd_idx_q;
    start_d     = 1'b0;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    have_data_d = have_data_q | rd_fire;
    wr_ptr_d    = accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
    overflow_d  = overflow_q | (sample_valid_i && !accept);
    occupancy_d = occupancy_q + OW'(accept);

    case (state_q)
      FILL: begin
        if (occupancy_q >= OW'(FRAME_SIZE)) begin
          state_d = START;
          start_d = 1'b1;
        end
      end
      START: begin
        rd_idx_d = '0;
        state_d  = SERVE;
      end
      SERVE: begin
        if (rd_idx_q == IW'(FRAME_SIZE)) begin
          state_d = ADVANCE;
          done_d  = 1'b1;
        end else if (rd_fire) begin
          rd_idx_d = rd_idx_q + IW'(1);
          valid_d  = 1'b1;
        end
      end
      ADVANCE: begin
        // Oldest HOP_SIZE samples retire; a same-cycle write still counts.
        base_ptr_d  = base_ptr_q + PW'(HOP_SIZE);
        occupancy_d = occupancy_q - OW'(HOP_SIZE) + OW'(accept);
        state_d     = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // State, pointer and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      base_ptr_q  <= '0;
      occupancy_q <= '0;
      rd_idx_q    <= '0;
      start_q     <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      have_data_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      base_ptr_q  <= base_ptr_d;
      occupancy_q <= occupancy_d;
      rd_idx_q    <= rd_idx_d;
      start_q     <= start_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      have_data_q <= have_data_d;
    end
  end

  // Simple dual-port RAM with registered read; kept reset-free so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_q] <= wr_data;
    end
    if (rd_fire) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  // Read data is masked until the first read after reset so the output starts at 0.
  assign frame_sample_o  = have_data_q ? rd_data_q : '0;
  assign start_o         = start_q;
  assign valid_to_read_o = valid_q;
  assign frame_done_o    = done_q;
  assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_framing_buffer.sv
// Self-checking bench for framing_buffer. Expected frames come from a
// stream model: frame k is stored samples [k*HOP, k*HOP+FRAME) of the
// accepted (optionally pre-emphasised) input stream.
module tb_framing_buffer;
  localparam int SW = 16;
  localparam int FS = 306;
  localparam int HS = 128;
  localparam int BD = 512;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic signed [SW-1:0] sample_i = '0;
  logic                 sample_valid_i = 1'b0;
  logic                 rd_en_i = 1'b0;
  logic                 start_o;
  logic signed [SW-1:0] frame_sample_o;
  logic                 valid_to_read_o;
  logic                 frame_done_o;
  logic                 overflow_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int retired = 0;
  int rd_viol = 0;
  logic prev_rd = 1'b0;
  longint model_prev = 0;

  logic signed [SW-1:0] got_data[$];
  int                   got_cyc[$];
  int                   start_cyc[$];
  int                   done_cyc[$];
  logic signed [SW-1:0] exp_stream[$];

  always #5 clk = ~clk;

  framing_buffer #(
    .SAMPLE_WIDTH(SW), .FRAME_SIZE(FS), .HOP_SIZE(HS), .BUFFER_DEPTH(BD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sample_i        (sample_i),
    .sample_valid_i  (sample_valid_i),
    .start_o         (start_o),
    .rd_en_i         (rd_en_i),
    .frame_sample_o  (frame_sample_o),
    .valid_to_read_o (valid_to_read_o),
    .frame_done_o    (frame_done_o),
    .overflow_o      (overflow_o)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor on the falling edge.
  always @(negedge clk) begin
    if (valid_to_read_o) begin
      got_data.push_back(frame_sample_o);
      got_cyc.push_back(cyc);
      if (!prev_rd) rd_viol++;
    end
    if (start_o) start_cyc.push_back(cyc);
    if (frame_done_o) done_cyc.push_back(cyc);
    prev_rd = rd_en_i;
  end

  function automatic logic signed [SW-1:0] model_proc(input logic signed [SW-1:0] x);
`ifdef PRE_EMPHASIS_EN
    longint p;
    longint y;
    p = (longint'(31785) * model_prev) >>> 15;
    y = longint'(x) - p;
    if (y > 32767) y = 32767;
    else if (y < -32768) y = -32768;
    model_prev = longint'(x);
    return SW'(y);
`else
    return x;
`endif
  endfunction

  task automatic clear_mon();
    got_data.delete();
    got_cyc.delete();
    start_cyc.delete();
    done_cyc.delete();
    rd_viol = 0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    sample_valid_i = 1'b0;
    rd_en_i = 1'b0;
    sample_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_stream.delete();
    retired = 0;
    model_prev = 0;
    clear_mon();
  endtask

  // Drive one sample; the model stores it only if the buffer has room.
  task automatic drive_sample(input logic signed [SW-1:0] x);
    sample_i = x;
    sample_valid_i = 1'b1;
    if (exp_stream.size() - retired * HS < BD) exp_stream.push_back(model_proc(x));
    @(posedge clk);
    #1;
    sample_valid_i = 1'b0;
    last_acc_cyc = cyc;
  endtask

  task automatic wait_done(input int count, input int budget);
    int n = 0;
    while (done_cyc.size() < count && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (done_cyc.size() < count) begin
      errors++;
      $display("FAIL frame_done_timeout: saw %0d frame_done pulses, required %0d", done_cyc.size(), count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({start_o, valid_to_read_o, frame_done_o, overflow_o} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0000", {start_o, valid_to_read_o, frame_done_o, overflow_o});
    end
    checks++;
    if (frame_sample_o !== '0) begin
      errors++;
      $display("FAIL reset_sample: got %0d required 0", frame_sample_o);
    end
    reset_dut();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (start_cyc.size() != 0 || got_data.size() != 0) begin
      errors++;
      $display("FAIL reset_idle: starts=%0d valids=%0d required 0/0", start_cyc.size(), got_data.size());
    end
  endtask

  task automatic test_frames_stream();
    int expect_start;
    reset_dut();
    rd_en_i = 1'b1;
    for (int f = 0; f < 6; f++) begin
      clear_mon();
      if (f == 0) begin
        for (int i = 0; i < FS; i++) drive_sample(SW'(i));
      end else if (f == 1) begin
        for (int i = FS; i < FS + HS; i++) drive_sample(SW'(i));
      end else begin
        for (int i = 0; i < HS; i++) drive_sample(SW'($urandom));
      end
      expect_start = last_acc_cyc + 1;
      wait_done(1, 1000);
      checks++;
      if (start_cyc.size() != 1 || start_cyc[0] != expect_start) begin
        errors++;
        $display("FAIL frame%0d_start: pulses=%0d cycle=%0d required 1 pulse at %0d", f, start_cyc.size(),
                 (start_cyc.size() > 0) ? start_cyc[0] : -1, expect_start);
      end
      checks++;
      if (got_data.size() != FS) begin
        errors++;
        $display("FAIL frame%0d_count: got %0d samples required %0d", f, got_data.size(), FS);
      end else begin
        for (int i = 0; i < FS; i++) begin
          checks++;
          if (got_data[i] !== exp_stream[f * HS + i]) begin
            errors++;
            $display("FAIL frame%0d_data[%0d]: got %0d required %0d", f, i, got_data[i], exp_stream[f * HS + i]);
          end
        end
        checks++;
        if (start_cyc.size() == 1 && (got_cyc[0] != start_cyc[0] + 2 || got_cyc[FS-1] != got_cyc[0] + FS - 1)) begin
          errors++;
          $display("FAIL frame%0d_read_timing: first=%0d last=%0d required %0d..%0d", f, got_cyc[0], got_cyc[FS-1],
                   start_cyc[0] + 2, start_cyc[0] + FS + 1);
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != got_cyc[FS-1] + 1) begin
          errors++;
          $display("FAIL frame%0d_done_timing: got cycle %0d required %0d", f,
                   (done_cyc.size() > 0) ? done_cyc[0] : -1, got_cyc[FS-1] + 1);
        end
      end
      retired++;
    end
    rd_en_i = 1'b0;
  endtask

  task automatic test_toggle_rd();
    int n;
    reset_dut();
    for (int f = 0; f < 2; f++) begin
      clear_mon();
      rd_en_i = 1'b0;
      for (int i = 0; i < ((f == 0) ? FS : HS); i++) drive_sample(SW'($urandom));
      n = 0;
      while (done_cyc.size() < 1 && n < 3000) begin
        if (f == 0) rd_en_i = ~rd_en_i;
        else rd_en_i = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        n++;
      end
      rd_en_i = 1'b0;
      checks++;
      if (done_cyc.size() != 1) begin
        errors++;
        $display("FAIL toggle%0d_done: got %0d pulses required 1", f, done_cyc.size());
      end
      checks++;
      if (got_data.size() != FS) begin
        errors++;
        $display("FAIL toggle%0d_count: got %0d samples required %0d", f, got_data.size(), FS);
      end else begin
        for (int i = 0; i < FS; i++) begin
          checks++;
          if (got_data[i] !== exp_stream[f * HS + i]) begin
            errors++;
            $display("FAIL toggle%0d_data[%0d]: got %0d required %0d", f, i, got_data[i], exp_stream[f * HS + i]);
          end
        end
      end
      checks++;
      if (rd_viol != 0) begin
        errors++;
        $display("FAIL toggle%0d_handshake: %0d valids without rd_en required 0", f, rd_viol);
      end
      retired++;
    end
  endtask

  task automatic test_overflow();
    reset_dut();
    rd_en_i = 1'b0;
    for (int i = 0; i < 600; i++) begin
      drive_sample(SW'(i));
      if (i == 511) begin
        checks++;
        if (overflow_o !== 1'b0) begin
          errors++;
          $display("FAIL overflow_early: got %b after 512 samples required 0", overflow_o);
        end
      end
      if (i == 512) begin
        checks++;
        if (overflow_o !== 1'b1) begin
          errors++;
          $display("FAIL overflow_rise: got %b after 513 samples required 1", overflow_o);
        end
      end
    end
    checks++;
    if (exp_stream.size() != BD) begin
      errors++;
      $display("FAIL overflow_model_fill: model stored %0d required %0d", exp_stream.size(), BD);
    end
    rd_en_i = 1'b1;
    wait_done(2, 2000);
    repeat (20) @(posedge clk);
    #1;
    rd_en_i = 1'b0;
    checks++;
    if (start_cyc.size() != 2) begin
      errors++;
      $display("FAIL overflow_frames: got %0d starts required 2", start_cyc.size());
    end
    checks++;
    if (got_data.size() != 2 * FS) begin
      errors++;
      $display("FAIL overflow_count: got %0d samples required %0d", got_data.size(), 2 * FS);
    end else begin
      for (int f = 0; f < 2; f++) begin
        for (int i = 0; i < FS; i++) begin
          checks++;
          if (got_data[f * FS + i] !== exp_stream[f * HS + i]) begin
            errors++;
            $display("FAIL overflow_data f%0d[%0d]: got %0d required %0d", f, i, got_data[f * FS + i],
                     exp_stream[f * HS + i]);
          end
        end
      end
    end
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b required 1", overflow_o);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    reset_dut();
    for (int i = 0; i < FS; i++) drive_sample(SW'($urandom));
    rd_en_i = 1'b1;
    while (got_data.size() < 100 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (got_data.size() != 100) begin
      errors++;
      $display("FAIL midreset_reach: got %0d reads required 100", got_data.size());
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({start_o, valid_to_read_o, frame_done_o, overflow_o} !== 4'b0 || frame_sample_o !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: flags=%b sample=%0d required 0000/0",
               {start_o, valid_to_read_o, frame_done_o, overflow_o}, frame_sample_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_stream.delete();
    retired = 0;
    model_prev = 0;
    clear_mon();
    rd_en_i = 1'b1;
    for (int i = 0; i < FS - 1; i++) drive_sample(SW'($urandom));
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (got_data.size() != 0 || start_cyc.size() != 0) begin
      errors++;
      $display("FAIL midreset_early_frame: valids=%0d starts=%0d required 0/0", got_data.size(), start_cyc.size());
    end
    drive_sample(SW'($urandom));
    wait_done(1, 1000);
    checks++;
    if (got_data.size() != FS) begin
      errors++;
      $display("FAIL midreset_count: got %0d samples required %0d", got_data.size(), FS);
    end else begin
      for (int i = 0; i < FS; i++) begin
        checks++;
        if (got_data[i] !== exp_stream[i]) begin
          errors++;
          $display("FAIL midreset_data[%0d]: got %0d required %0d", i, got_data[i], exp_stream[i]);
        end
      end
    end
    rd_en_i = 1'b0;
  endtask

`ifdef PRE_EMPHASIS_EN
  task automatic test_pre_emphasis();
    logic signed [SW-1:0] first_v[2];
    logic signed [SW-1:0] req[2];
    for (int t = 0; t < 2; t++) begin
      reset_dut();
      if (t == 0) begin
        first_v[0] = 16'sd1000;  first_v[1] = 16'sd1000;
        req[0]     = 16'sd1000;  req[1]     = 16'sd30;
      end else begin
        first_v[0] = 16'sd32767; first_v[1] = -16'sd32768;
        req[0]     = 16'sd32767; req[1]     = -16'sd32768;
      end
      drive_sample(first_v[0]);
      drive_sample(first_v[1]);
      for (int i = 2; i < FS; i++) drive_sample(SW'($urandom));
      rd_en_i = 1'b1;
      wait_done(1, 1000);
      rd_en_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_data.size() <= i || got_data[i] !== req[i]) begin
          errors++;
          $display("FAIL preemph%0d_sample%0d: got %0d required %0d", t, i,
                   (got_data.size() > i) ? got_data[i] : 16'sd0, req[i]);
        end
      end
      for (int i = 2; i < FS && i < got_data.size(); i++) begin
        checks++;
        if (got_data[i] !== exp_stream[i]) begin
          errors++;
          $display("FAIL preemph%0d_data[%0d]: got %0d required %0d", t, i, got_data[i], exp_stream[i]);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frames_stream();
    test_toggle_rd();
    test_overflow();
    test_reset_mid_frame();
`ifdef PRE_EMPHASIS_EN
    test_pre_emphasis();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
